// File: rtl/rv_pipe_pkg.sv
// Shared RV32 front-end definitions: base opcodes, the canonical NOP, field
// bit positions and the fetch-to-decode payload type.
package rv_pipe_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  // ADDI x0,x0,0
  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

  localparam int OPC_LSB    = 0;
  localparam int OPC_MSB    = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7B5   = 30;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

  // 32-bit encodings always end in 2'b11; anything else is compressed or illegal here.
  function automatic logic is_32b_encoding(input logic [1:0] low_bits);
    return low_bits == 2'b11;
  endfunction

endpackage

// File: rtl/rv_instr_field_split.sv
// Combinational slicer for the RV32 base-format decode fields, shared by the
// IF/ID register and the ID stage.
module rv_instr_field_split
  import rv_pipe_pkg::*;
#(
  parameter int ILEN = 32
) (
  input  logic            valid,
  input  logic [ILEN-1:0] instr,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            funct7b5,
  output logic            illegal
);

  if (ILEN < 32) begin : g_bad_ilen
    $error("rv_instr_field_split: ILEN must be at least 32");
  end

  assign opcode   = instr[OPC_MSB:OPC_LSB];
  assign rd       = instr[RD_MSB:RD_LSB];
  assign funct3   = instr[FUNCT3_MSB:FUNCT3_LSB];
  assign rs1      = instr[RS1_MSB:RS1_LSB];
  assign rs2      = instr[RS2_MSB:RS2_LSB];
  assign funct7b5 = instr[FUNCT7B5];
  assign illegal  = valid && !is_32b_encoding(instr[1:0]);

  // Remaining funct7 bits are decoded downstream, not here.
  logic unused_bits;
  if (ILEN > 32) begin : g_wide
    assign unused_bits = ^{instr[ILEN-1:32], instr[31], instr[29:25]};
  end else begin : g_narrow
    assign unused_bits = ^{instr[31], instr[29:25]};
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: valid/ready with a 2-entry skid buffer, redirect
// flush, NOP bubble when empty and pre-split decode fields.
module if_id_pipe_reg
  import rv_pipe_pkg::*;
#(
  parameter int              ILEN      = 32,
  parameter int              PC_WIDTH  = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(RV_NOP_INSTR)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ILEN-1:0]     in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ILEN-1:0]     out_instr,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [6:0]          out_opcode,
  output logic [4:0]          out_rd,
  output logic [2:0]          out_funct3,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic                out_funct7b5,
  output logic                out_illegal
);

  logic                h_valid_q, h_valid_d;
  logic [ILEN-1:0]     h_instr_q, h_instr_d;
  logic [PC_WIDTH-1:0] h_pc_q,    h_pc_d;
  logic                s_valid_q, s_valid_d;
  logic [ILEN-1:0]     s_instr_q, s_instr_d;
  logic [PC_WIDTH-1:0] s_pc_q,    s_pc_d;
  logic                in_ready_q, in_ready_d;

  logic in_fire;
  logic head_free;

  assign in_fire   = in_valid && in_ready_q;
  // Head can take a new entry when empty or when decode is taking it this cycle.
  assign head_free = !h_valid_q || out_ready;

  always_comb begin
    h_valid_d = h_valid_q;
    h_instr_d = h_instr_q;
    h_pc_d    = h_pc_q;
    s_valid_d = s_valid_q;
    s_instr_d = s_instr_q;
    s_pc_d    = s_pc_q;

    if (flush) begin
      h_valid_d = 1'b0;
      h_instr_d = NOP_INSTR;
      h_pc_d    = '0;
      s_valid_d = 1'b0;
    end else if (head_free) begin
      // in_ready is low whenever the skid is full, so the skid always wins here.
      if (s_valid_q) begin
        h_valid_d = 1'b1;
        h_instr_d = s_instr_q;
        h_pc_d    = s_pc_q;
        s_valid_d = 1'b0;
      end else if (in_fire) begin
        h_valid_d = 1'b1;
        h_instr_d = in_instr;
        h_pc_d    = in_pc;
      end else begin
        h_valid_d = 1'b0;
        h_instr_d = NOP_INSTR;
        h_pc_d    = '0;
      end
    end else if (in_fire) begin
      s_valid_d = 1'b1;
      s_instr_d = in_instr;
      s_pc_d    = in_pc;
    end

    in_ready_d = !s_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_valid_q  <= 1'b0;
      h_instr_q  <= NOP_INSTR;
      h_pc_q     <= '0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      h_valid_q  <= h_valid_d;
      h_instr_q  <= h_instr_d;
      h_pc_q     <= h_pc_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Skid payload is qualified by s_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    s_instr_q <= s_instr_d;
    s_pc_q    <= s_pc_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = h_valid_q;
  assign out_instr = h_instr_q;
  assign out_pc    = h_pc_q;

  rv_instr_field_split #(
    .ILEN(ILEN)
  ) u_split (
    .valid    (h_valid_q),
    .instr    (h_instr_q),
    .opcode   (out_opcode),
    .rd       (out_rd),
    .funct3   (out_funct3),
    .rs1      (out_rs1),
    .rs2      (out_rs2),
    .funct7b5 (out_funct7b5),
    .illegal  (out_illegal)
  );

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg with hand-computed expected values.
module tb_if_id_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic        out_funct7b5;
  logic        out_illegal;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] ADD_I = 32'h00A3_0333; // add x6,x6,x10
  localparam logic [31:0] SUB_I = 32'h4031_00B3; // sub x1,x2,x3
  localparam logic [31:0] NOP_I = 32'h0000_0013;

  always #5 clk = ~clk;

  if_id_pipe_reg dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_opcode   (out_opcode),
    .out_rd       (out_rd),
    .out_funct3   (out_funct3),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_funct7b5 (out_funct7b5),
    .out_illegal  (out_illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".valid"},   64'(out_valid),   64'd0);
    check({tag, ".instr"},   64'(out_instr),   64'(NOP_I));
    check({tag, ".pc"},      64'(out_pc),      64'd0);
    check({tag, ".opcode"},  64'(out_opcode),  64'h13);
    check({tag, ".rd"},      64'(out_rd),      64'd0);
    check({tag, ".funct3"},  64'(out_funct3),  64'd0);
    check({tag, ".rs1"},     64'(out_rs1),     64'd0);
    check({tag, ".rs2"},     64'(out_rs2),     64'd0);
    check({tag, ".f7b5"},    64'(out_funct7b5), 64'd0);
    check({tag, ".illegal"}, 64'(out_illegal), 64'd0);
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;

    // Reset then idle
    step();
    step();
    check_empty("rst");
    check("rst.in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    step();
    check_empty("idle");
    check("idle.in_ready", 64'(in_ready), 64'd1);

    // Single transfer
    out_ready = 1'b1;
    send(ADD_I, 32'h100);
    check("single.valid",   64'(out_valid),    64'd1);
    check("single.opcode",  64'(out_opcode),   64'h33);
    check("single.rd",      64'(out_rd),       64'd6);
    check("single.rs1",     64'(out_rs1),      64'd6);
    check("single.rs2",     64'(out_rs2),      64'd10);
    check("single.funct3",  64'(out_funct3),   64'd0);
    check("single.f7b5",    64'(out_funct7b5), 64'd0);
    check("single.pc",      64'(out_pc),       64'h100);
    check("single.illegal", 64'(out_illegal),  64'd0);
    step();
    check_empty("single_drain");

    // Back-pressure into the skid
    out_ready = 1'b0;
    send(ADD_I, 32'h200);
    check("bp.in_ready1", 64'(in_ready), 64'd1);
    send(SUB_I, 32'h204);
    check("bp.in_ready0", 64'(in_ready), 64'd0);
    step();
    check("bp.hold_instr", 64'(out_instr), 64'(ADD_I));
    check("bp.hold_pc",    64'(out_pc),    64'h200);
    check("bp.hold_ready", 64'(in_ready),  64'd0);
    out_ready = 1'b1;
    #1;
    check("bp.emit_add", 64'(out_instr), 64'(ADD_I));
    step();
    check("bp.sub_valid", 64'(out_valid),    64'd1);
    check("bp.sub_instr", 64'(out_instr),    64'(SUB_I));
    check("bp.sub_rd",    64'(out_rd),       64'd1);
    check("bp.sub_rs1",   64'(out_rs1),      64'd2);
    check("bp.sub_rs2",   64'(out_rs2),      64'd3);
    check("bp.sub_f7b5",  64'(out_funct7b5), 64'd1);
    check("bp.sub_pc",    64'(out_pc),       64'h204);
    check("bp.in_ready",  64'(in_ready),     64'd1);
    step();
    check("bp.no_dup", 64'(out_valid), 64'd0);

    // Streaming, one per clock
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_instr = NOP_I | (32'(i) << 7);
      in_pc    = 32'(i * 4);
      step();
      check($sformatf("stream%0d.valid", i), 64'(out_valid), 64'd1);
      check($sformatf("stream%0d.pc", i),    64'(out_pc),    64'(i * 4));
      check($sformatf("stream%0d.rd", i),    64'(out_rd),    64'(i));
      check($sformatf("stream%0d.ready", i), 64'(in_ready),  64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream.drain", 64'(out_valid), 64'd0);

    // Flush with full skid and concurrent in_valid
    out_ready = 1'b0;
    send(ADD_I, 32'h300);
    send(SUB_I, 32'h304);
    check("flush.skid_full", 64'(in_ready), 64'd0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0000_0033; in_pc = 32'h308;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_empty("flush_full");
    check("flush_full.in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    check("flush_full.no_ghost", 64'(out_valid), 64'd0);

    // Flush drops an accepted input in the same cycle
    out_ready = 1'b0;
    send(ADD_I, 32'h400);
    flush = 1'b1; in_valid = 1'b1; in_instr = SUB_I; in_pc = 32'h404;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_fire.valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    step();
    check("flush_fire.dropped", 64'(out_valid), 64'd0);
    check("flush_fire.pc",      64'(out_pc),    64'd0);

    // Illegal encoding, then reset mid-stream with skid full
    out_ready = 1'b0;
    send(32'hFFFF_FFFC, 32'h500);
    check("illegal.valid", 64'(out_valid),   64'd1);
    check("illegal.flag",  64'(out_illegal), 64'd1);
    send(ADD_I, 32'h504);
    check("illegal.skid", 64'(in_ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_empty("midrst");
    check("midrst.in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    check("midrst.skid_gone", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Parametrised IF/ID pipeline register between the fetch stage and the decoder/register-file read stage.
- Captures the fetched instruction and its PC, then presents pre-split decode fields: opcode, rd, funct3, rs1, rs2 and funct7[5].
- Adds what a bare latch lacks: a valid/ready handshake with a 2-entry skid buffer (full throughput, registered in_ready), flush for branch/jump redirect, a NOP bubble on empty, and an illegal-encoding flag.

Parameters:
- ILEN, 32, instruction width in bits; field positions are fixed per RV32 base format, so ILEN must be >= 32.
- PC_WIDTH, 32, width of the carried program counter.
- NOP_INSTR, 32'h0000_0013, instruction presented whenever out_valid=0 (ADDI x0,x0,0).

Ports:
- clk  in  1  rising-edge clock; the block has one clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  block can accept; registered, equals !skid_valid.
- in_instr  in  ILEN  fetched instruction.
- in_pc  in  PC_WIDTH  PC of in_instr.
- flush  in  1  discard all held entries (redirect).
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode stage accepts the head entry.
- out_instr  out  ILEN  head instruction, NOP_INSTR when empty.
- out_pc  out  PC_WIDTH  head PC, 0 when empty.
- out_opcode  out  7  out_instr[6:0].
- out_rd  out  5  out_instr[11:7].
- out_funct3  out  3  out_instr[14:12].
- out_rs1  out  5  out_instr[19:15].
- out_rs2  out  5  out_instr[24:20].
- out_funct7b5  out  1  out_instr[30].
- out_illegal  out  1  out_valid && out_instr[1:0] != 2'b11.

Behaviour:
- Storage:
  - Head entry: h_valid, h_instr, h_pc.
  - Skid entry: s_valid, s_instr, s_pc.
  - All decode fields are combinational slices of h_instr (already registered).
- Reset (rst=1 at a rising edge): h_valid=0, s_valid=0, h_instr=NOP_INSTR, h_pc=0. Resulting outputs:
  - in_ready=1, out_valid=0.
  - out_opcode=7'h13; out_rd, out_funct3, out_rs1, out_rs2, out_funct7b5 all 0.
  - out_illegal=0.
  - Reset mid-stream drops both entries with no partial state.
- Transfers:
  - in_fire = in_valid && in_ready.
  - out_fire = out_valid && out_ready.
- Latency: an accepted instruction appears on out_* the cycle after in_fire when the head is empty or draining. Sustained throughput is 1 instr/clk with out_ready held at 1.
- Head update each cycle (no flush):
  - If !h_valid or out_fire: head loads the skid entry if s_valid; else loads the input if in_fire; else h_valid=0 and h_instr=NOP_INSTR.
  - Otherwise the head holds.
- Skid update:
  - s_valid is set when in_fire occurs while the head is valid and not draining (h_valid && !out_ready).
  - s_valid is cleared when the skid moves to the head.
  - in_ready is registered: next in_ready = !next s_valid.
- Flush (highest priority below rst):
  - h_valid=0, s_valid=0, h_instr=NOP_INSTR, h_pc=0.
  - An in_fire in the same cycle is dropped.
  - in_ready=1 the following cycle.
  - out_fire in the flush cycle still counts as consumed by decode.
- Ordering: strictly FIFO; the skid entry is never overtaken by the input.
- Values when out_valid=0:
  - out_instr=NOP_INSTR; out_pc must read 0.
  - out_illegal=0.
- The in_pc width is passed through unchanged; no arithmetic in the block.

Decomposition:
- Shared package rv_pipe_pkg:
  - OPC_OP=7'h33, OPC_OPIMM=7'h13, OPC_LOAD=7'h03, OPC_STORE=7'h23, OPC_BRANCH=7'h63, OPC_JAL=7'h6F.
  - NOP_INSTR constant.
  - Field bit-position constants.
  - Packed struct if_id_t {instr, pc}.
- One natural sub-module: rv_instr_field_split, a combinational slicer producing opcode/rd/funct3/rs1/rs2/funct7b5/illegal. The ID stage reuses it.

Test Plan:
- Reset then idle: rst=1 for 2 clks, release -> out_valid=0, in_ready=1, out_instr=32'h00000013, out_opcode=7'h13, all register fields 0.
- Single transfer: in_instr=32'h00A30333 (add x6,x6,x10), in_pc=32'h100, out_ready=1 -> next cycle out_valid=1, opcode=7'h33, rd=6, rs1=6, rs2=10, funct3=0, funct7b5=0, out_pc=32'h100.
- Back-pressure: out_ready=0 while sending 32'h00A30333 then 32'h403100B3 (sub x1,x2,x3) -> second goes to skid and in_ready=0. Raise out_ready -> add emitted, then sub with rd=1, rs1=2, rs2=3, funct7b5=1, no loss or duplication.
- Streaming: 16 consecutive instrs with both valid/ready=1 -> one output per clk, PCs 0x0..0x3C in order.
- Flush with full skid plus concurrent in_valid -> next cycle out_valid=0, out_instr=NOP, in_ready=1, dropped input never appears.
- Illegal encoding: in_instr=32'hFFFFFFFC -> out_illegal=1 while valid; reset asserted mid-stream -> all outputs return to reset values in 1 clk.
